multdiv: RTL and testbench
==========================

# multdiv

Sequential signed 32-bit multiply/divide unit that sits beside `alu` in the execute stage. `alu` covers single-cycle add/subtract; this block covers the multi-cycle operations. Each operation is started by a one-cycle control pulse and takes a fixed 33-cycle iterative run. Completion is reported with a one-cycle ready strobe, and the result stays held for the processor's stall logic.

## Interface
Parameters:
- none. Width is fixed at 32 bits to match `alu` operands.

Ports:
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `data_operandA`  in  32  multiplicand / dividend, two's complement
- `data_operandB`  in  32  multiplier / divisor, two's complement
- `ctrl_MULT`  in  1  start-multiply pulse, sampled on rising edge
- `ctrl_DIV`  in  1  start-divide pulse, sampled on rising edge
- `data_result`  out  32  product low word or quotient; held until next start
- `data_exception`  out  1  overflow / divide-by-zero flag; valid with `data_result`
- `data_resultRDY`  out  1  one-cycle completion strobe

## Operation
- States: IDLE, MUL, DIV, DONE.
  - IDLE: waits for a start pulse.
  - MUL/DIV: iterate with a 6-bit counter from 0 to 31.
  - DONE: asserts `data_resultRDY` for one cycle, then returns to IDLE.
- Start:
  - The edge that samples `ctrl_MULT=1` or `ctrl_DIV=1` latches both operands into internal registers.
  - After that edge, operand inputs are don't-care.
- Both pulses high on the same edge: multiply wins and the divide request is dropped.
- Start pulse while in MUL, DIV or DONE: the current operation aborts with no RDY strobe for it.
  - The new operands are latched.
  - The counter restarts at 0.
- Multiply: radix-2 shift-add on operand magnitudes; sign is applied at the end.
  - Full 64-bit product is formed internally.
  - `data_result` = product[31:0].
  - `data_exception` = 1 iff product[63:31] are not all equal, i.e. the product does not fit in signed 32 bits.
- Divide: restoring division on magnitudes. Quotient truncates toward zero; quotient sign = signA XOR signB. Remainder is discarded. Special cases:
  - B = 0: `data_result` = 0, `data_exception` = 1. The unit still runs the full 33 cycles.
  - A = 0x80000000 and B = 0xFFFFFFFF: `data_result` = 0x80000000, `data_exception` = 1.
  - All other cases: `data_exception` = 0.
- `data_result` and `data_exception` update only on the edge that enters DONE. They hold through IDLE and through a following operation until its own DONE.

## Timing
- Edge 0 samples the start pulse. Edges 1–32 perform the 32 iterations.
- Edge 33 enters DONE and registers the result.
- `data_resultRDY` is high from edge 33 to edge 34, exactly one cycle. Latency from start edge to RDY high is 33 cycles.
- Back-to-back use: a start pulse on edge 34 (the cycle RDY is high) is accepted. Its RDY rises at edge 67.
- Reset, asynchronous, effective without a clock edge, including mid-operation:
  - State goes to IDLE, the counter clears, and no RDY is produced for the interrupted operation.
  - Outputs: `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
- On reset deassertion, the first start pulse is accepted on the next rising edge.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Test plan
- Multiply 7 × −6:
  - A = 7, B = 0xFFFFFFFA, one-cycle `ctrl_MULT`.
  - Required: RDY exactly 33 cycles later for one cycle, `data_result` = 0xFFFFFFD6, `data_exception` = 0.
- Multiply overflow:
  - A = 0x00010000, B = 0x00010000.
  - Required: `data_result` = 0x00000000, `data_exception` = 1.
- Divide −7 / 2:
  - A = 0xFFFFFFF9, B = 2, `ctrl_DIV`.
  - Required: `data_result` = 0xFFFFFFFD, `data_exception` = 0, RDY after 33 cycles.
- Divide special cases:
  - 5 / 0 → `data_result` = 0, `data_exception` = 1, RDY still at 33 cycles.
  - 0x80000000 / −1 → `data_result` = 0x80000000, `data_exception` = 1.
- Abort and restart:
  - Start 100 / 7, then pulse `ctrl_MULT` with 3 × 4 at cycle 10.
  - Required: no RDY for the divide; RDY at 33 cycles after the multiply start, `data_result` = 12.
- Reset mid-operation:
  - Assert `reset` asynchronously at cycle 15 of a multiply.
  - Required: all outputs 0 immediately and no RDY.
  - After release, 9 × 9 yields 81 with RDY at 33 cycles.

Source files
------------

// File: rtl/multdiv.sv
// multdiv -- sequential signed 32-bit multiply / divide unit.
//
// Purpose: multi-cycle companion to the single-cycle alu. A one-cycle start
// pulse (ctrl_MULT or ctrl_DIV) latches the operands. A fixed 32-iteration
// radix-2 engine then runs: shift-add for multiply, restoring division for
// divide. Both work on operand magnitudes, and the sign is applied when the
// result is registered. data_resultRDY pulses for one cycle 33 cycles after
// the start edge. data_result/data_exception then hold until the next
// completion.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high reset
//   data_operandA  in   [31:0] multiplicand / dividend (two's complement)
//   data_operandB  in   [31:0] multiplier / divisor (two's complement)
//   ctrl_MULT      in   start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV       in   start-divide pulse
//   data_result    out  [31:0] product low word or quotient
//   data_exception out  overflow / divide-by-zero flag
//   data_resultRDY out  one-cycle completion strobe
module multdiv (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [63:0] work_q, work_d;
  // Multiply: |A| added on each set multiplier bit. Divide: |B|.
  logic [31:0] addend_q, addend_d;
  logic        neg_q, neg_d;
  logic        div_zero_q, div_zero_d;
  logic        div_ovf_q, div_ovf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_step;
  logic [32:0] rem_shift;
  logic [33:0] div_diff;
  logic [63:0] div_step;
  logic [63:0] prod_signed;
  logic [31:0] quot_signed;

  // Magnitude of 0x80000000 is 0x80000000, which still fits unsigned 32 bits.
  assign mag_a = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign mag_b = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  assign mul_sum  = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, addend_q} : 33'd0);
  assign mul_step = {mul_sum, work_q[31:1]};

  // The remainder stays below a divisor of at most 2^31, so after a
  // successful subtract it fits back into the 32-bit upper half.
  assign rem_shift = work_q[63:31];
  assign div_diff  = {1'b0, rem_shift} - {2'b00, addend_q};
  assign div_step  = div_diff[33] ? {rem_shift[31:0], work_q[30:0], 1'b0}
                                  : {div_diff[31:0],  work_q[30:0], 1'b1};

  assign prod_signed = neg_q ? (~work_q + 64'd1) : work_q;
  assign quot_signed = neg_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    work_d     = work_q;
    addend_d   = addend_q;
    neg_d      = neg_q;
    div_zero_d = div_zero_q;
    div_ovf_d  = div_ovf_q;
    result_d   = result_q;
    exc_d      = exc_q;

    if (ctrl_MULT || ctrl_DIV) begin
      // A start from any state aborts the running operation.
      count_d    = 6'd0;
      neg_d      = data_operandA[31] ^ data_operandB[31];
      div_zero_d = (data_operandB == 32'd0);
      div_ovf_d  = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
      if (ctrl_MULT) begin
        state_d  = MUL;
        work_d   = {32'd0, mag_b};
        addend_d = mag_a;
      end else begin
        state_d  = DIV;
        work_d   = {32'd0, mag_a};
        addend_d = mag_b;
      end
    end else begin
      case (state_q)
        MUL: begin
          if (count_q != 6'd32) begin
            work_d  = mul_step;
            count_d = count_q + 6'd1;
          end else begin
            state_d  = DONE;
            result_d = prod_signed[31:0];
            // Fits in signed 32 bits only if bits 63..31 are a pure sign extension.
            exc_d    = !((&prod_signed[63:31]) || !(|prod_signed[63:31]));
          end
        end
        DIV: begin
          if (count_q != 6'd32) begin
            work_d  = div_step;
            count_d = count_q + 6'd1;
          end else begin
            state_d = DONE;
            if (div_zero_q) begin
              result_d = 32'd0;
              exc_d    = 1'b1;
            end else if (div_ovf_q) begin
              result_d = 32'h8000_0000;
              exc_d    = 1'b1;
            end else begin
              result_d = quot_signed;
              exc_d    = 1'b0;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    rdy_d = (state_d == DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 6'd0;
      work_q     <= 64'd0;
      addend_q   <= 32'd0;
      neg_q      <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= 32'd0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      work_q     <= work_d;
      addend_q   <= addend_d;
      neg_q      <= neg_d;
      div_zero_q <= div_zero_d;
      div_ovf_q  <= div_ovf_d;
      result_q   <= result_d;
      exc_q      <= exc_d;
      rdy_q      <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv -- self-checking bench for multdiv.
// A table of vectors is applied in a loop. Each start pushes its expected
// result onto a scoreboard queue, and a monitor pops and compares on every
// RDY strobe. Hand-written sequences cover back-to-back operation, abort and
// restart, and reset in the middle of an operation.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  multdiv dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    chk_cnt++;
    if (act === req) begin
      pass_cnt++;
      $display("check %s: got %h ok", name, act);
    end else begin
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  // Scoreboard monitor: every RDY strobe must match the oldest outstanding start.
  always @(negedge clock) begin
    if (!reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_rdy: actual RDY=1 at cycle %0d required no strobe", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, "_result"}, data_result, e.res);
        check({e.name, "_exception"}, {31'd0, data_exception}, {31'd0, e.exc});
        check({e.name, "_latency"}, cyc - e.start_cyc, 32'd33);
      end
    end
  end

  // Called at a negedge. The start edge is the following posedge.
  // Operands are scrambled afterwards because they are don't-care.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b,
                          input logic m, input logic d, input logic push,
                          input logic [31:0] res, input logic exc, input string name);
    exp_t e;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    if (push) begin
      e.res = res; e.exc = exc; e.start_cyc = cyc + 1; e.name = name;
      sb.push_back(e);
    end
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk_cnt++;
      $display("FAIL %s_timeout: actual %0d results pending required 0", name, sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic        m, d;
    logic [31:0] res;
    logic        exc;
    string       name;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{32'd7,         32'hFFFF_FFFA, 1'b1, 1'b0, 32'hFFFF_FFD6, 1'b0, "mul_7x-6"};
    vecs[1]  = '{32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, "mul_ovf"};
    vecs[2]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, "div_-7/2"};
    vecs[3]  = '{32'd5,         32'd0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, "div_by_0"};
    vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, "div_min/-1"};
    vecs[5]  = '{32'h8000_0000, 32'd1,         1'b1, 1'b0, 32'h8000_0000, 1'b0, "mul_min_x1"};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1, "mul_min_x-1"};
    vecs[7]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'd15,        1'b0, "mul_-3x-5"};
    vecs[8]  = '{32'h7FFF_FFFF, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1, "mul_max_x2"};
    vecs[9]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd14,        1'b0, "div_100/7"};
    vecs[10] = '{32'd7,         32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, "div_7/-2"};
    vecs[11] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b1, 32'd14,        1'b0, "div_-100/-7"};
    vecs[12] = '{32'd0,         32'd5,         1'b0, 1'b1, 32'd0,         1'b0, "div_0/5"};
    vecs[13] = '{32'h8000_0000, 32'd2,         1'b0, 1'b1, 32'hC000_0000, 1'b0, "div_min/2"};
    vecs[14] = '{32'd6,         32'd7,         1'b1, 1'b1, 32'd42,        1'b0, "both_pulses"};

    // Reset state.
    repeat (2) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].d, 1'b1,
               vecs[i].res, vecs[i].exc, vecs[i].name);
      wait_done(vecs[i].name);
      repeat (2) @(negedge clock);
      check({vecs[i].name, "_hold"}, data_result, vecs[i].res);
    end

    // Back-to-back: new start on the cycle RDY is high.
    start_op(32'd11, 32'd3, 1'b1, 1'b0, 1'b1, 32'd33, 1'b0, "b2b_first");
    begin
      int n;
      n = 0;
      while (!data_resultRDY && n < 60) begin
        @(negedge clock);
        n++;
      end
      check("b2b_rdy_seen", {31'd0, data_resultRDY}, 32'd1);
    end
    start_op(32'd20, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFB, 1'b0, "b2b_second");
    wait_done("b2b_second");

    // Abort: divide started, multiply issued ten cycles later.
    start_op(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, "abort_div");
    repeat (9) @(negedge clock);
    start_op(32'd3, 32'd4, 1'b1, 1'b0, 1'b1, 32'd12, 1'b0, "abort_mul");
    wait_done("abort_mul");
    repeat (5) @(negedge clock);

    // Reset mid-operation. data_result is currently 12, so clearing is observable.
    start_op(32'd5, 32'd5, 1'b1, 1'b0, 1'b1, 32'd25, 1'b0, "reset_victim");
    repeat (14) @(negedge clock);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exception", {31'd0, data_exception}, 32'd0);
    check("midreset_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    start_op(32'd9, 32'd9, 1'b1, 1'b0, 1'b1, 32'd81, 1'b0, "after_reset_9x9");
    wait_done("after_reset_9x9");
    repeat (40) @(negedge clock);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
